hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Tracks destination-register tags of in-flight instructions through the EXE, MEM and WB stages of the ARM pipeline and decides, from the decode-stage source operands, whether the ID stage must stall. It produces the per-stage destination and write-enable tags consumed by the forwarding logic. It also produces a busy mask of registers with writes pending and a saturating stall-cycle counter. It sits between the ID/EXE boundary and the forwarding select logic.

## Interface
- REG_W, 4, register-index width (16 architectural registers)
- CNT_W, 16, stall-cycle counter width
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  REG_W  first source register (always used when id_valid)
- id_src2  in  REG_W  second source register
- id_two_src  in  1  id_src2 is actually read
- id_dest  in  REG_W  destination register of ID instruction
- id_wb_en  in  1  ID instruction writes id_dest
- id_mem_read  in  1  ID instruction is a load (LDR)
- flush  in  1  branch taken in EXE; kill ID instruction
- stall  out  1  hold PC and IF/ID; insert bubble into EXE
- exe_dest, mem_dest, wb_dest  out  REG_W  per-stage destination tags
- exe_wb_en, mem_wb_en, wb_wb_en  out  1  per-stage write-enable tags
- exe_mem_read  out  1  EXE stage holds a load
- busy_mask  out  16  bit r = 1 if any of EXE/MEM/WB has wb_en with dest r
- stall_cnt  out  CNT_W  saturating count of cycles with stall = 1

## Operation
- Tag pipeline: three registered stages EXE→MEM→WB, each holding {dest, wb_en, mem_read}. Entries advance every rising clk edge; the WB entry retires.
- EXE load rule:
  - Accept when id_valid & !stall & !flush; the EXE stage loads the ID fields.
  - Otherwise the EXE stage loads a bubble: wb_en = 0, mem_read = 0, dest = 0.
- Source match:
  - src1 hits stage S if id_valid & S.wb_en & (id_src1 == S.dest).
  - src2 hits stage S under the same condition, additionally gated by id_two_src.
- Stall decision: see Configuration. stall is forced to 0 while flush = 1; flush has priority.
- busy_mask: combinational OR of one-hot decodes of the three stage dest values. A stage contributes only when its wb_en = 1.
- stall_cnt: increments by 1 on each edge where stall = 1. It saturates at 2^CNT_W − 1 and does not wrap.
- MEM and WB stages never stall. A bubble in EXE propagates normally.

## Timing
- stall is combinational from the id_* inputs, flush and the registered stage tags. It is valid in the same cycle as the ID inputs.
- Latency: an instruction accepted at edge N appears on exe_* after edge N, on mem_* after N+1 and on wb_* after N+2. It is absent from busy_mask after N+3.
- Register file writes in WB complete before ID reads (negedge write), so the WB stage never causes a stall.
- A stalled instruction is re-evaluated each cycle. Stall clears once the producer has advanced past the hazard window.
- Reset (asynchronous, at any time, including mid-stall):
  - All stage tags go to 0 and stall_cnt goes to 0.
  - busy_mask and stall therefore read 0 while rst_n = 0 and in the first cycle after release, provided flush = 0 or id_valid = 0.

## Configuration
- HAZARD_FWD_EN defined (forwarding present):
  - Stall only on load-use, i.e. a src1 or src2 hit on EXE with exe_mem_read = 1.
  - All other dependences are resolved by forwarding from MEM/WB.
- HAZARD_FWD_EN undefined:
  - Stall on any src1 or src2 hit on EXE or MEM, regardless of mem_read.
- Tag outputs, busy_mask and stall_cnt behave identically in both builds.

## Test plan
- Reset, then ID `ADD r1` with wb_en=1 at edge 0 → exe_dest=1 and exe_wb_en=1 after edge 0; mem_dest=1 after edge 1; wb_dest=1 after edge 2; busy_mask=0x0000 after edge 3.
- `LDR r2` accepted, next ID instruction reads src1=r2:
  - HAZARD_FWD_EN build: stall=1 for exactly 1 cycle, EXE gets a bubble, stall_cnt=1.
  - Non-forwarding build: stall=2 cycles, stall_cnt=2.
- `ADD r3` followed by `SUB` reading r3 as src2 with id_two_src=0 → stall=0 in both builds. Repeating with id_two_src=1 → stall=0 with HAZARD_FWD_EN; 2 stall cycles without it.
- Load-use hazard with flush=1 in the same cycle → stall=0, EXE loads a bubble (exe_wb_en=0), stall_cnt unchanged.
- Force continuous stall with CNT_W=4 → stall_cnt reaches 15 and holds at 15.
- Assert rst_n=0 mid-stall with three valid entries in flight → all tags, busy_mask, stall and stall_cnt read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Bundles the ID-stage request, flush, stall and per-stage tag outputs of hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_read;
    logic             flush;

    logic             stall;
    logic [REG_W-1:0] exe_dest;
    logic [REG_W-1:0] mem_dest;
    logic [REG_W-1:0] wb_dest;
    logic             exe_wb_en;
    logic             mem_wb_en;
    logic             wb_wb_en;
    logic             exe_mem_read;
    logic [15:0]      busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read, flush,
        input  stall, exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
               exe_mem_read, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read, flush,
        output stall, exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
               exe_mem_read, busy_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// EXE/MEM/WB destination-tag pipeline with ID-stage stall decision, busy mask and stall counter.
// Define HAZARD_FWD_EN for the forwarding build (stall only on load-use).
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } tag_t;

    tag_t             r_exe;
    tag_t             r_mem;
    tag_t             r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    tag_t             w_exe_next;
    logic             w_src_hit_exe;
    logic             w_src_hit_mem;
    logic             w_stall;
    logic [15:0]      w_busy;

    always_comb begin
        w_src_hit_exe = bus.id_valid && r_exe.wb_en &&
                        ((bus.id_src1 == r_exe.dest) ||
                         (bus.id_two_src && (bus.id_src2 == r_exe.dest)));
        w_src_hit_mem = bus.id_valid && r_mem.wb_en &&
                        ((bus.id_src1 == r_mem.dest) ||
                         (bus.id_two_src && (bus.id_src2 == r_mem.dest)));
    end

    // WB writes the register file on the falling edge, so it never participates.
    always_comb begin
`ifdef HAZARD_FWD_EN
        w_stall = !bus.flush && w_src_hit_exe && r_exe.mem_read;
`else
        w_stall = !bus.flush && (w_src_hit_exe || w_src_hit_mem);
`endif
    end

    always_comb begin
        // NOTE: defaulting every field first keeps this block free of inferred latches.
        w_exe_next = '0;
        if (bus.id_valid && !w_stall && !bus.flush) begin
            w_exe_next.dest     = bus.id_dest;
            w_exe_next.wb_en    = bus.id_wb_en;
            w_exe_next.mem_read = bus.id_mem_read;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int r = 0; r < 16; r++) begin
            w_busy[r] = (r_exe.wb_en && (r_exe.dest == REG_W'(r))) ||
                        (r_mem.wb_en && (r_mem.dest == REG_W'(r))) ||
                        (r_wb.wb_en  && (r_wb.dest  == REG_W'(r)));
        end
    end

    // NOTE: non-blocking assignments let all three stages shift from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe       <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_exe <= w_exe_next;
            r_mem <= r_exe;
            r_wb  <= r_mem;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.exe_dest     = r_exe.dest;
    assign bus.exe_wb_en    = r_exe.wb_en;
    assign bus.exe_mem_read = r_exe.mem_read;
    assign bus.mem_dest     = r_mem.dest;
    assign bus.mem_wb_en    = r_mem.wb_en;
    assign bus.wb_dest      = r_wb.dest;
    assign bus.wb_wb_en     = r_wb.wb_en;
    assign bus.busy_mask    = w_busy;
    assign bus.stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CNT_W=4) with a queue-fed reference pipeline model.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_read;
    } tag_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    tag_t       q[$];
    tag_t       m_exe, m_mem, m_wb;
    logic [3:0] m_cnt;

    hazard_scoreboard_if #(.REG_W(4), .CNT_W(4)) bus ();

    hazard_scoreboard #(.REG_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(tag_t s, logic v, logic [3:0] s1, logic [3:0] s2, logic two);
        return v && s.wb_en && ((s1 == s.dest) || (two && (s2 == s.dest)));
    endfunction

    function automatic logic [15:0] busy_of(tag_t a, tag_t b, tag_t c);
        logic [15:0] m;
        m = '0;
        if (a.wb_en) m[a.dest] = 1'b1;
        if (b.wb_en) m[b.dest] = 1'b1;
        if (c.wb_en) m[c.dest] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_exe = '0;
        m_mem = '0;
        m_wb  = '0;
        m_cnt = '0;
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exe_dest"}, 32'(bus.exe_dest), 0);
        check({tag, "_exe_wb"},   32'(bus.exe_wb_en), 0);
        check({tag, "_exe_mr"},   32'(bus.exe_mem_read), 0);
        check({tag, "_mem_wb"},   32'(bus.mem_wb_en), 0);
        check({tag, "_wb_wb"},    32'(bus.wb_wb_en), 0);
        check({tag, "_busy"},     32'(bus.busy_mask), 0);
        check({tag, "_stall"},    32'(bus.stall), 0);
        check({tag, "_cnt"},      32'(bus.stall_cnt), 0);
    endtask

    // Called at a falling edge: drive ID, check stall, clock once, check the stages.
    task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb,
                        input logic mr, input logic fl, output logic obs_stall);
        logic exp_stall;
        tag_t exp_exe;
        bus.id_valid    = v;
        bus.id_src1     = s1;
        bus.id_src2     = s2;
        bus.id_two_src  = two;
        bus.id_dest     = d;
        bus.id_wb_en    = wb;
        bus.id_mem_read = mr;
        bus.flush       = fl;
        #1;
`ifdef HAZARD_FWD_EN
        exp_stall = !fl && hit(m_exe, v, s1, s2, two) && m_exe.mem_read;
`else
        exp_stall = !fl && (hit(m_exe, v, s1, s2, two) || hit(m_mem, v, s1, s2, two));
`endif
        obs_stall = bus.stall;
        check("stall", 32'(bus.stall), 32'(exp_stall));
        q.push_back((v && !exp_stall && !fl) ? tag_t'{dest: d, wb_en: wb, mem_read: mr} : tag_t'('0));
        if (exp_stall && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        @(posedge clk);
        #1;
        m_wb  = m_mem;
        m_mem = m_exe;
        m_exe = q.pop_front();
        check("exe_dest", 32'(bus.exe_dest), 32'(m_exe.dest));
        check("exe_wb",   32'(bus.exe_wb_en), 32'(m_exe.wb_en));
        check("exe_mr",   32'(bus.exe_mem_read), 32'(m_exe.mem_read));
        check("mem_dest", 32'(bus.mem_dest), 32'(m_mem.dest));
        check("mem_wb",   32'(bus.mem_wb_en), 32'(m_mem.wb_en));
        check("wb_dest",  32'(bus.wb_dest), 32'(m_wb.dest));
        check("wb_wb",    32'(bus.wb_wb_en), 32'(m_wb.wb_en));
        check("busy",     32'(bus.busy_mask), 32'(busy_of(m_exe, m_mem, m_wb)));
        check("cnt",      32'(bus.stall_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        logic s;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, s);
    endtask

    // Presents one instruction until accepted (bounded); returns observed stall cycles.
    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic [3:0] d, input logic wb, input logic mr,
                         output int n_stall);
        logic s;
        n_stall = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, s1, s2, two, d, wb, mr, 0, s);
            if (!s) return;
            n_stall++;
        end
        check("issue_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int   n;
        int   exp_n;
        logic s;
        logic [3:0] cnt_before;

        bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
        bus.id_dest = 0; bus.id_wb_en = 0; bus.id_mem_read = 0; bus.flush = 0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // ADD r1 through the pipeline and out of busy_mask
        step(1, 0, 0, 0, 4'd1, 1, 0, 0, s);
        check("add_exe_dest", 32'(bus.exe_dest), 1);
        check("add_busy_e0", 32'(bus.busy_mask), 32'h0002);
        nop(1);
        check("add_mem_dest", 32'(bus.mem_dest), 1);
        nop(1);
        check("add_wb_dest", 32'(bus.wb_dest), 1);
        nop(1);
        check("add_busy_e3", 32'(bus.busy_mask), 32'h0000);

        // LDR r2 then a src1=r2 consumer
        issue(0, 0, 0, 4'd2, 1, 1, n);
        check("ldr_accept_stalls", n, 0);
        issue(4'd2, 0, 0, 4'd6, 1, 0, n);
`ifdef HAZARD_FWD_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        check("load_use_stalls", n, exp_n);
        check("load_use_cnt", 32'(bus.stall_cnt), exp_n);
        nop(3);

        // ADD r3, SUB reading r3 on src2 without id_two_src
        issue(0, 0, 0, 4'd3, 1, 0, n);
        issue(0, 4'd3, 0, 4'd7, 1, 0, n);
        check("src2_unused_stalls", n, 0);
        nop(3);
        issue(0, 0, 0, 4'd3, 1, 0, n);
        issue(0, 4'd3, 1, 4'd7, 1, 0, n);
`ifdef HAZARD_FWD_EN
        check("src2_used_stalls", n, 0);
`else
        check("src2_used_stalls", n, 2);
`endif
        nop(3);

        // Load-use with flush in the same cycle
        issue(0, 0, 0, 4'd4, 1, 1, n);
        cnt_before = bus.stall_cnt;
        step(1, 4'd4, 0, 0, 4'd8, 1, 0, 1, s);
        check("flush_stall", 32'(s), 0);
        check("flush_exe_wb", 32'(bus.exe_wb_en), 0);
        check("flush_cnt", 32'(bus.stall_cnt), 32'(cnt_before));
        nop(3);

        // Saturate the 4-bit stall counter with repeated load-use pairs
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(0, 0, 0, 4'd5, 1, 1, n);
            issue(4'd5, 0, 0, 4'd6, 0, 0, n);
        end
        check("sat_cnt", 32'(bus.stall_cnt), 15);
        issue(0, 0, 0, 4'd5, 1, 1, n);
        issue(4'd5, 0, 0, 4'd6, 0, 0, n);
        check("sat_hold_stalled", n, exp_n);
        check("sat_hold_cnt", 32'(bus.stall_cnt), 15);

        // Asynchronous reset mid-stall with three valid entries in flight
        do_reset();
        issue(0, 0, 0, 4'd7, 1, 0, n);
        issue(0, 0, 0, 4'd8, 1, 0, n);
        issue(0, 0, 0, 4'd9, 1, 1, n);
        bus.id_valid = 1; bus.id_src1 = 4'd9; bus.id_two_src = 0;
        bus.id_dest = 4'd10; bus.id_wb_en = 1; bus.id_mem_read = 0; bus.flush = 0;
        #1;
        check("pre_rst_stall", 32'(bus.stall), 1);
        check("pre_rst_busy", 32'(bus.busy_mask), 32'h0380);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.id_valid = 0;
        #1;
        check("post_rst_stall", 32'(bus.stall), 0);
        nop(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
